// File: rtl/bus_resp_return_pkg.sv
// Shared definitions for the crossbar response return path: index widths
// and the one-hot to binary index conversion used for the in-order FIFO.
package bus_resp_return_pkg;

    // Widest decode vector the index helper accepts (NS+1 must fit here)
    localparam int ONEHOT_MAX_W = 64;
    localparam int IDX_MAX_W    = 6;

    // OR together the positions of all set bits; exact for a one-hot input
    function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input logic [ONEHOT_MAX_W-1:0] vec);
        logic [IDX_MAX_W-1:0] idx_s;
        idx_s = {IDX_MAX_W{1'b0}};
        for (int i = 0; i < ONEHOT_MAX_W; i++) begin
            idx_s = idx_s | ({IDX_MAX_W{vec[i]}} & IDX_MAX_W'(i));
        end
        return idx_s;
    endfunction

endpackage

// File: rtl/bus_resp_return_if.sv
// Bundles the decoded request, per-slave return signals and the master-side
// response of the crossbar return path.
interface bus_resp_return_if #(
    parameter int NS      = 8,
    parameter int DW      = 32,
    parameter int LGDEPTH = 3
);
    logic                i_abort;
    logic                i_req_valid;
    logic                o_req_stall;
    logic [NS:0]         i_req_decode;
    logic [NS-1:0]       o_slv_stb;
    logic [NS-1:0]       i_slv_stall;
    logic [NS-1:0]       i_slv_ack;
    logic [NS-1:0]       i_slv_err;
    logic [NS*DW-1:0]    i_slv_data;
    logic                o_ack;
    logic                o_err;
    logic [DW-1:0]       o_data;
    logic [LGDEPTH:0]    o_outstanding;
    logic                o_fault;

    // Return-path block side
    modport slave (
        input  i_abort, i_req_valid, i_req_decode, i_slv_stall, i_slv_ack, i_slv_err, i_slv_data,
        output o_req_stall, o_slv_stb, o_ack, o_err, o_data, o_outstanding, o_fault
    );

    // Environment side: master request plus the slaves' returns
    modport master (
        output i_abort, i_req_valid, i_req_decode, i_slv_stall, i_slv_ack, i_slv_err, i_slv_data,
        input  o_req_stall, o_slv_stb, o_ack, o_err, o_data, o_outstanding, o_fault
    );
endinterface

// File: rtl/bus_resp_return_idx_fifo.sv
// In-order FIFO of slave indices with synchronous flush and a fill count.
module bus_resp_return_idx_fifo #(
    parameter int W       = 4,
    parameter int LGDEPTH = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [W-1:0]     i_push_data,
    input  logic             i_pop,
    output logic [W-1:0]     o_head,
    output logic [LGDEPTH:0] o_fill,
    output logic             o_full,
    output logic             o_empty
);
    localparam int DEPTH = 2**LGDEPTH;

    logic [W-1:0]         mem_r [DEPTH];
    logic [LGDEPTH-1:0]   wr_ptr_r;
    logic [LGDEPTH-1:0]   rd_ptr_r;
    logic [LGDEPTH:0]     fill_r;

    // Pointers wrap naturally; fill tracks push/pop and is cleared by flush
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            wr_ptr_r <= {LGDEPTH{1'b0}};
            rd_ptr_r <= {LGDEPTH{1'b0}};
            fill_r   <= {(LGDEPTH+1){1'b0}};
        end else begin
            if (i_push) begin
                wr_ptr_r <= wr_ptr_r + LGDEPTH'(1);
            end
            if (i_pop) begin
                rd_ptr_r <= rd_ptr_r + LGDEPTH'(1);
            end
            case ({i_push, i_pop})
                2'b10:   fill_r <= fill_r + (LGDEPTH+1)'(1);
                2'b01:   fill_r <= fill_r - (LGDEPTH+1)'(1);
                default: fill_r <= fill_r;
            endcase
        end
    end

    // Storage: entries are only meaningful below the fill level, so no reset
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush && !i_reset) begin
            mem_r[wr_ptr_r] <= i_push_data;
        end
    end

    assign o_head  = mem_r[rd_ptr_r];
    assign o_fill  = fill_r;
    assign o_full  = (fill_r == (LGDEPTH+1)'(DEPTH));
    assign o_empty = (fill_r == {(LGDEPTH+1){1'b0}});

endmodule

// File: rtl/bus_resp_return.sv
// Crossbar return path: gates decoded requests to slaves, remembers their
// order, accepts responses only from the slave at the head of that order and
// synthesises bus-error responses for requests that decoded to no slave.
module bus_resp_return
    import bus_resp_return_pkg::*;
#(
    parameter int NS           = 8,
    parameter int DW           = 32,
    parameter int LGDEPTH      = 3,
    parameter bit OPT_LOWPOWER = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    bus_resp_return_if.slave bus
);
    localparam int IDXW = $clog2(NS+1);

    logic             full_s;
    logic             empty_s;
    logic             stall_s;
    logic             accept_s;
    logic             pop_s;
    logic             stray_ack_s;
    logic             head_is_err_s;
    logic             head_ack_s;
    logic             resp_err_s;
    logic [IDXW-1:0]  push_idx_s;
    logic [IDXW-1:0]  head_s;
    logic [NS-1:0]    head_mask_s;
    logic [DW-1:0]    resp_data_s;
    logic [LGDEPTH:0] fill_s;

    logic             ack_r;
    logic             err_r;
    logic [DW-1:0]    data_r;
    logic             fault_r;

    // Full comes from registered fill, so a same-cycle pop never admits a push
    assign stall_s    = full_s || (|(bus.i_req_decode[NS-1:0] & bus.i_slv_stall)) || bus.i_abort;
    assign accept_s   = bus.i_req_valid && !stall_s;
    assign push_idx_s = IDXW'(onehot_to_idx(ONEHOT_MAX_W'(bus.i_req_decode)));

    assign bus.o_req_stall = stall_s;
    assign bus.o_slv_stb   = accept_s ? bus.i_req_decode[NS-1:0] : {NS{1'b0}};

    // Head decode: select the one slave whose response may be returned next
    always_comb begin
        head_mask_s = {NS{1'b0}};
        resp_data_s = {DW{1'b0}};
        resp_err_s  = 1'b0;
        for (int k = 0; k < NS; k++) begin
            head_mask_s[k] = (head_s == IDXW'(k));
            resp_data_s    = resp_data_s | ({DW{head_mask_s[k]}} & bus.i_slv_data[k*DW +: DW]);
            resp_err_s     = resp_err_s | (head_mask_s[k] & bus.i_slv_err[k]);
        end
    end

    // A no-slave head pops on its own; a slave head pops on that slave's ack
    assign head_is_err_s = (head_s == IDXW'(NS));
    assign head_ack_s    = |(bus.i_slv_ack & head_mask_s);
    assign pop_s         = !empty_s && !bus.i_abort && (head_is_err_s || head_ack_s);
    assign stray_ack_s   = !empty_s && (|(bus.i_slv_ack & ~head_mask_s));

    bus_resp_return_idx_fifo #(
        .W       (IDXW),
        .LGDEPTH (LGDEPTH)
    ) u_idx_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_flush     (bus.i_abort),
        .i_push      (accept_s),
        .i_push_data (push_idx_s),
        .i_pop       (pop_s),
        .o_head      (head_s),
        .o_fill      (fill_s),
        .o_full      (full_s),
        .o_empty     (empty_s)
    );

    // Registered response to the master plus the sticky protocol-fault flag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            data_r  <= {DW{1'b0}};
            fault_r <= 1'b0;
        end else if (bus.i_abort) begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            if (OPT_LOWPOWER) begin
                data_r <= {DW{1'b0}};
            end
        end else begin
            ack_r   <= pop_s;
            fault_r <= fault_r | stray_ack_s;
            if (pop_s) begin
                err_r  <= head_is_err_s | resp_err_s;
                data_r <= head_is_err_s ? {DW{1'b0}} : resp_data_s;
            end else begin
                err_r <= 1'b0;
                if (OPT_LOWPOWER) begin
                    data_r <= {DW{1'b0}};
                end
            end
        end
    end

    assign bus.o_ack         = ack_r;
    assign bus.o_err         = err_r;
    assign bus.o_data        = data_r;
    assign bus.o_outstanding = fill_s;
    assign bus.o_fault       = fault_r;

endmodule

// File: tb/tb_bus_resp_return.sv
// Self-checking bench for bus_resp_return with NS=4, DW=32, LGDEPTH=2.
module tb_bus_resp_return;

    localparam int NS      = 4;
    localparam int DW      = 32;
    localparam int LGDEPTH = 2;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   model_out;
    exp_t exp_q[$];

    bus_resp_return_if #(.NS(NS), .DW(DW), .LGDEPTH(LGDEPTH)) bus();

    bus_resp_return #(
        .NS(NS), .DW(DW), .LGDEPTH(LGDEPTH), .OPT_LOWPOWER(1'b0)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.i_abort      = 1'b0;
        bus.i_req_valid  = 1'b0;
        bus.i_req_decode = '0;
        bus.i_slv_ack    = '0;
        bus.i_slv_err    = '0;
    endtask

    task automatic drive_req(input int k);
        bus.i_req_valid     = 1'b1;
        bus.i_req_decode    = '0;
        bus.i_req_decode[k] = 1'b1;
    endtask

    task automatic drive_ack(input int k, input logic e, input logic [DW-1:0] d);
        bus.i_slv_ack              = '0;
        bus.i_slv_ack[k]           = 1'b1;
        bus.i_slv_err[k]           = e;
        bus.i_slv_data[k*DW +: DW] = d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_inputs();
        bus.i_slv_stall = '0;
        bus.i_slv_data  = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (bus.o_outstanding !== 3'd0 || bus.o_ack !== 1'b0 || bus.o_err !== 1'b0 ||
            bus.o_data !== 32'd0 || bus.o_fault !== 1'b0 || bus.o_slv_stb !== 4'd0) begin
            bad++;
            $display("FAIL reset: out=%0d ack=%b err=%b data=%h fault=%b stb=%b, expected all zero",
                     bus.o_outstanding, bus.o_ack, bus.o_err, bus.o_data, bus.o_fault, bus.o_slv_stb);
        end
        model_out = 0;
    endtask

    task automatic test_in_order;
        int            sl[3];
        logic [3:0]    es;
        logic [DW-1:0] d;
        exp_t          e;
        sl = '{2, 0, 3};
        for (int i = 0; i < 3; i++) begin
            drive_req(sl[i]);
            #1;
            es = 4'b0001 << sl[i];
            total++;
            if (bus.o_slv_stb !== es || bus.o_req_stall !== 1'b0) begin
                bad++;
                $display("FAIL in_order_stb: stb=%b stall=%b expected stb=%b stall=0",
                         bus.o_slv_stb, bus.o_req_stall, es);
            end
            tick();
            model_out++;
        end
        clear_inputs();
        total++;
        if (bus.o_outstanding !== 3'(model_out)) begin
            bad++;
            $display("FAIL in_order_out: got %0d expected %0d", bus.o_outstanding, model_out);
        end
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            drive_ack(sl[i], 1'b0, d);
            exp_q.push_back('{err: 1'b0, data: d});
            tick();
            model_out--;
            e = exp_q.pop_front();
            total++;
            if (bus.o_ack !== 1'b1 || bus.o_err !== e.err || bus.o_data !== e.data ||
                bus.o_outstanding !== 3'(model_out)) begin
                bad++;
                $display("FAIL in_order_resp: ack=%b err=%b data=%h out=%0d expected ack=1 err=%b data=%h out=%0d",
                         bus.o_ack, bus.o_err, bus.o_data, bus.o_outstanding, e.err, e.data, model_out);
            end
            clear_inputs();
        end
    endtask

    task automatic test_no_slave;
        exp_t e;
        bus.i_req_valid  = 1'b1;
        bus.i_req_decode = 5'b10000;
        #1;
        total++;
        if (bus.o_slv_stb !== 4'd0 || bus.o_req_stall !== 1'b0) begin
            bad++;
            $display("FAIL no_slave_stb: stb=%b stall=%b expected 0000 0", bus.o_slv_stb, bus.o_req_stall);
        end
        tick();
        clear_inputs();
        exp_q.push_back('{err: 1'b1, data: 32'd0});
        total++;
        if (bus.o_ack !== 1'b0 || bus.o_outstanding !== 3'd1) begin
            bad++;
            $display("FAIL no_slave_pending: ack=%b out=%0d expected 0 1", bus.o_ack, bus.o_outstanding);
        end
        tick();
        e = exp_q.pop_front();
        total++;
        if (bus.o_ack !== 1'b1 || bus.o_err !== e.err || bus.o_data !== e.data || bus.o_outstanding !== 3'd0) begin
            bad++;
            $display("FAIL no_slave_resp: ack=%b err=%b data=%h out=%0d expected 1 1 0 0",
                     bus.o_ack, bus.o_err, bus.o_data, bus.o_outstanding);
        end
        tick();
        total++;
        if (bus.o_ack !== 1'b0) begin
            bad++;
            $display("FAIL no_slave_onecycle: ack=%b expected 0", bus.o_ack);
        end
    endtask

    task automatic test_wrong_slave;
        exp_t e;
        drive_req(1);
        tick();
        clear_inputs();
        drive_ack(2, 1'b0, 32'hDEAD_0002);
        tick();
        clear_inputs();
        total++;
        if (bus.o_ack !== 1'b0 || bus.o_fault !== 1'b1 || bus.o_outstanding !== 3'd1) begin
            bad++;
            $display("FAIL wrong_slave_fault: ack=%b fault=%b out=%0d expected 0 1 1",
                     bus.o_ack, bus.o_fault, bus.o_outstanding);
        end
        drive_ack(1, 1'b1, 32'h1111_0001);
        exp_q.push_back('{err: 1'b1, data: 32'h1111_0001});
        tick();
        clear_inputs();
        e = exp_q.pop_front();
        total++;
        if (bus.o_ack !== 1'b1 || bus.o_err !== e.err || bus.o_data !== e.data || bus.o_fault !== 1'b1) begin
            bad++;
            $display("FAIL wrong_slave_resp: ack=%b err=%b data=%h fault=%b expected 1 %b %h 1",
                     bus.o_ack, bus.o_err, bus.o_data, bus.o_fault, e.err, e.data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus.o_fault !== 1'b0 || bus.o_ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_clears_fault: fault=%b ack=%b expected 0 0", bus.o_fault, bus.o_ack);
        end
    endtask

    task automatic test_full;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive_req(0);
            tick();
        end
        total++;
        if (bus.o_outstanding !== 3'd4) begin
            bad++;
            $display("FAIL full_out: got %0d expected 4", bus.o_outstanding);
        end
        drive_req(0);
        #1;
        total++;
        if (bus.o_req_stall !== 1'b1 || bus.o_slv_stb !== 4'd0) begin
            bad++;
            $display("FAIL full_stall: stall=%b stb=%b expected 1 0000", bus.o_req_stall, bus.o_slv_stb);
        end
        drive_ack(0, 1'b0, 32'hF00D_0000);
        exp_q.push_back('{err: 1'b0, data: 32'hF00D_0000});
        tick();
        bus.i_slv_ack = '0;
        e = exp_q.pop_front();
        total++;
        if (bus.o_ack !== 1'b1 || bus.o_data !== e.data || bus.o_outstanding !== 3'd3 ||
            bus.o_req_stall !== 1'b0 || bus.o_slv_stb !== 4'b0001) begin
            bad++;
            $display("FAIL full_pop: ack=%b data=%h out=%0d stall=%b stb=%b expected 1 %h 3 0 0001",
                     bus.o_ack, bus.o_data, bus.o_outstanding, bus.o_req_stall, bus.o_slv_stb, e.data);
        end
        tick();
        clear_inputs();
        total++;
        if (bus.o_outstanding !== 3'd4) begin
            bad++;
            $display("FAIL full_refill: got %0d expected 4", bus.o_outstanding);
        end
        for (int i = 0; i < 4; i++) begin
            drive_ack(0, 1'b0, 32'(i + 32'h50));
            exp_q.push_back('{err: 1'b0, data: 32'(i + 32'h50)});
            tick();
            clear_inputs();
            e = exp_q.pop_front();
            total++;
            if (bus.o_ack !== 1'b1 || bus.o_data !== e.data || bus.o_outstanding !== 3'(3 - i)) begin
                bad++;
                $display("FAIL full_drain: ack=%b data=%h out=%0d expected 1 %h %0d",
                         bus.o_ack, bus.o_data, bus.o_outstanding, e.data, 3 - i);
            end
        end
    endtask

    task automatic test_slave_stall;
        exp_t e;
        bus.i_slv_stall = 4'b0001;
        drive_req(0);
        #1;
        total++;
        if (bus.o_req_stall !== 1'b1 || bus.o_slv_stb !== 4'd0) begin
            bad++;
            $display("FAIL stall_blocked: stall=%b stb=%b expected 1 0000", bus.o_req_stall, bus.o_slv_stb);
        end
        drive_req(1);
        #1;
        total++;
        if (bus.o_req_stall !== 1'b0 || bus.o_slv_stb !== 4'b0010) begin
            bad++;
            $display("FAIL stall_other: stall=%b stb=%b expected 0 0010", bus.o_req_stall, bus.o_slv_stb);
        end
        tick();
        clear_inputs();
        bus.i_slv_stall = 4'b0000;
        drive_ack(1, 1'b0, 32'hABCD_1234);
        exp_q.push_back('{err: 1'b0, data: 32'hABCD_1234});
        tick();
        clear_inputs();
        e = exp_q.pop_front();
        total++;
        if (bus.o_ack !== 1'b1 || bus.o_data !== e.data || bus.o_outstanding !== 3'd0) begin
            bad++;
            $display("FAIL stall_resp: ack=%b data=%h out=%0d expected 1 %h 0",
                     bus.o_ack, bus.o_data, bus.o_outstanding, e.data);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        drive_req(3);
        tick();
        drive_req(2);
        drive_ack(3, 1'b0, 32'h3333_3333);
        exp_q.push_back('{err: 1'b0, data: 32'h3333_3333});
        tick();
        clear_inputs();
        e = exp_q.pop_front();
        total++;
        if (bus.o_ack !== 1'b1 || bus.o_data !== e.data || bus.o_outstanding !== 3'd1) begin
            bad++;
            $display("FAIL b2b_pushpop: ack=%b data=%h out=%0d expected 1 %h 1",
                     bus.o_ack, bus.o_data, bus.o_outstanding, e.data);
        end
        drive_ack(2, 1'b1, 32'h2222_2222);
        exp_q.push_back('{err: 1'b1, data: 32'h2222_2222});
        tick();
        clear_inputs();
        e = exp_q.pop_front();
        total++;
        if (bus.o_ack !== 1'b1 || bus.o_err !== e.err || bus.o_data !== e.data || bus.o_outstanding !== 3'd0) begin
            bad++;
            $display("FAIL b2b_second: ack=%b err=%b data=%h out=%0d expected 1 %b %h 0",
                     bus.o_ack, bus.o_err, bus.o_data, bus.o_outstanding, e.err, e.data);
        end
    endtask

    task automatic test_abort;
        for (int i = 0; i < 3; i++) begin
            drive_req(i);
            tick();
        end
        clear_inputs();
        total++;
        if (bus.o_outstanding !== 3'd3) begin
            bad++;
            $display("FAIL abort_pre: got %0d expected 3", bus.o_outstanding);
        end
        drive_req(3);
        bus.i_abort = 1'b1;
        #1;
        total++;
        if (bus.o_req_stall !== 1'b1 || bus.o_slv_stb !== 4'd0) begin
            bad++;
            $display("FAIL abort_stall: stall=%b stb=%b expected 1 0000", bus.o_req_stall, bus.o_slv_stb);
        end
        tick();
        clear_inputs();
        total++;
        if (bus.o_outstanding !== 3'd0 || bus.o_ack !== 1'b0) begin
            bad++;
            $display("FAIL abort_flush: out=%0d ack=%b expected 0 0", bus.o_outstanding, bus.o_ack);
        end
        for (int i = 0; i < 3; i++) begin
            drive_ack(i, 1'b0, 32'hBAD0_0000);
            tick();
            clear_inputs();
            total++;
            if (bus.o_ack !== 1'b0 || bus.o_fault !== 1'b0 || bus.o_outstanding !== 3'd0) begin
                bad++;
                $display("FAIL abort_late_ack: ack=%b fault=%b out=%0d expected 0 0 0",
                         bus.o_ack, bus.o_fault, bus.o_outstanding);
            end
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        test_reset();
        test_in_order();
        test_no_slave();
        test_wrong_slave();
        test_full();
        test_slave_stall();
        test_back_to_back();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
